// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
//   Sequential BCD-to-binary converter (reverse double dabble). A packed
//   DIGITS-digit BCD word is captured on an enable request and converted one
//   bit per clock; after BIN_W shifts the binary value is presented on
//   data_out together with a one-cycle done pulse.
//
// Optional feature macro: BCD_ERR_CHECK_EN
//   defined   : digits > 9 in the captured word are flagged; the conversion
//               still runs its full length, then done comes with err=1 and
//               data_out=0.
//   undefined : no check logic, err is tied low.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous active-low reset
//   enable    in   1         start request, honoured in IDLE or DONE only
//   bcd_in    in   4*DIGITS  packed BCD word, digit 0 in [3:0]
//   data_out  out  BIN_W     binary result, updated on the done edge only
//   done      out  1         one-cycle pulse, data_out/err valid
//   err       out  1         invalid-digit flag, valid with done
// -----------------------------------------------------------------------------
module bcd_to_binary #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      data_out,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // The largest BCD value must fit in the binary output.
  if ((64'd10 ** DIGITS) - 64'd1 >= (64'd1 << BIN_W)) begin : g_width_bad
    $error("bcd_to_binary: BIN_W too small for DIGITS");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   data_out_q, data_out_d;
  logic               done_q, done_d;
  logic               capture;

  // One step of the combined shift register: bcd LSB drops into bin MSB.
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_fix;
  logic [BIN_W-1:0]   bin_shift;

  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

  // A shifted digit >= 8 (MSB set) held an odd tens-carry from the digit
  // above; subtracting 3 halves it back into decimal weight. Each digit is
  // corrected on its own 4 bits, no borrow crosses digits.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_fix
    assign bcd_fix[4*gi +: 4] = bcd_shift[4*gi+3] ? (bcd_shift[4*gi +: 4] - 4'd3)
                                                  : bcd_shift[4*gi +: 4];
  end

`ifdef BCD_ERR_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  logic              bad_any;
  logic              err_flag_q, err_flag_d;
  logic              err_q, err_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
  end
  assign bad_any = |digit_bad;
`endif

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    capture    = 1'b0;
`ifdef BCD_ERR_CHECK_EN
    err_flag_d = err_flag_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) capture = 1'b1;
      end
      ST_SHIFT: begin
        bcd_d = bcd_fix;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          data_out_d = bin_shift;
`ifdef BCD_ERR_CHECK_EN
          err_d = err_flag_q;
          if (err_flag_q) data_out_d = '0;
`endif
        end
      end
      ST_DONE: begin
        if (enable) capture = 1'b1;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared by IDLE and DONE so back-to-back requests behave like fresh ones.
    if (capture) begin
      state_d = ST_SHIFT;
      bcd_d   = bcd_in;
      bin_d   = '0;
      cnt_d   = '0;
`ifdef BCD_ERR_CHECK_EN
      err_flag_d = bad_any;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

`ifdef BCD_ERR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_flag_q <= err_flag_d;
      err_q      <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [11:0]       bcd_in = 12'h000;
  logic [BIN_W-1:0]  data_out;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bcd_in   (bcd_in),
    .data_out (data_out),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int bcd_value(input logic [11:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [11:0] b);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Model: a request is accepted whenever not busy; the result appears
  // BIN_W edges later as a one-cycle pulse, and data_out holds afterwards.
  int  m_busy    = 0;
  int  m_pending = 0;
  bit  m_pend_bad = 1'b0;
  bit  m_done    = 1'b0;
  bit  m_err     = 1'b0;
  int  m_data    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 1'b0; m_err <= 1'b0; m_data <= 0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      m_done <= (m_busy == 1);
      m_err  <= 1'b0;
      if (m_busy == 1) begin
`ifdef BCD_ERR_CHECK_EN
        m_data <= m_pend_bad ? 0 : m_pending;
        m_err  <= m_pend_bad;
`else
        m_data <= m_pending;
`endif
      end
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (enable) begin
        m_pending  <= bcd_value(bcd_in);
        m_pend_bad <= bcd_bad(bcd_in);
        m_busy     <= BIN_W;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_done", int'(done), int'(m_done));
      check("model_data", int'(data_out), m_data);
      check("model_err",  int'(err), int'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic start(input logic [11:0] v, output int c0);
    @(posedge clk); #1;
    bcd_in = v; enable = 1'b1;
    @(posedge clk); #1;            // capture edge just passed
    enable = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s: done timeout got 0 expected 1", name);
    end
  endtask

  task automatic convert(input string name, input logic [11:0] v, input int exp);
    int c0; bit ok;
    start(v, c0);
    wait_done(name, ok);
    if (ok) begin
      check(name, int'(data_out), exp);
      check({name, "_lat"}, cyc - c0, BIN_W);
      $display("txn %s bcd=%h data_out=%0d err=%0d", name, v, data_out, err);
    end
  endtask

  initial begin
    int c0; bit ok; int last_done; int v;

    // Reset values
    #12;
    check("rst_data", int'(data_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_err",  int'(err), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic conversions (literal expectations pin the model)
    convert("zero", 12'h000, 0);
    check("zero_err", int'(err), 0);
    convert("h255", 12'h255, 255);
    convert("h999", 12'h999, 999);
    convert("h001", 12'h001, 1);
    convert("h080", 12'h080, 80);

    // Back-to-back sweep with enable held high
    @(posedge clk); #1;
    bcd_in = to_bcd(100); enable = 1'b1;
    last_done = -1;
    for (v = 100; v <= 255; v++) begin
      @(posedge clk); #1;           // capture edge for v
      if (v < 255) bcd_in = to_bcd(v + 1);
      else         enable = 1'b0;
      wait_done("sweep", ok);
      if (!ok) break;
      check("sweep_val", int'(data_out), v);
      if (last_done >= 0) check("sweep_gap", cyc - last_done, BIN_W + 1);
      last_done = cyc;
      $display("txn sweep bcd=%h data_out=%0d", to_bcd(v), data_out);
    end
    enable = 1'b0;
    repeat (3) @(posedge clk);

    // bcd_in changed after capture must not matter
    start(12'h123, c0);
    @(posedge clk); #1;
    bcd_in = 12'h321;
    wait_done("late_change", ok);
    if (ok) check("late_change", int'(data_out), 123);
    $display("txn late_change data_out=%0d", data_out);

    // Reset in the middle of a conversion
    start(12'h876, c0);
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("midrst_data", int'(data_out), 0);
    check("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      check("midrst_nodone", int'(done), 0);
    end
    $display("txn midrst data_out=%0d", data_out);
    convert("h042", 12'h042, 42);

`ifdef BCD_ERR_CHECK_EN
    start(12'h1A5, c0);
    wait_done("bad_digit", ok);
    if (ok) begin
      check("bad_err",  int'(err), 1);
      check("bad_data", int'(data_out), 0);
    end
    $display("txn bad_digit err=%0d data_out=%0d", err, data_out);
    convert("h105", 12'h105, 105);
    check("h105_err", int'(err), 0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
